// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded control and operand fields,
// squashes control on flush or failed condition, and counts inserted bubbles.
module id_ex_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic [8:0]        ctrl_in,
  input  logic              cond_pass,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm24_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic              carry_in,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              b,
  output logic              s,
  output logic [3:0]        exe_cmd,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic              imm,
  output logic [11:0]       shift_operand,
  output logic [23:0]       signed_imm24,
  output logic [3:0]        dest,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic              carry,
  output logic              valid,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned CTRL_W = 9;
  localparam int unsigned DBUS_W = 3 * DATA_W + 1 + 12 + 24 + 3 * 4 + 1;

  logic [DBUS_W-1:0] data_in_c;
  logic [DBUS_W-1:0] data_d, data_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic              valid_d, valid_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              bubble_c;

  assign data_in_c = {pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
                      signed_imm24_in, dest_in, src1_in, src2_in, carry_in};

  // Next-state: flush beats freeze beats load; a failed condition loads a bubble.
  always_comb begin
    data_d   = data_q;
    ctrl_d   = ctrl_q;
    valid_d  = valid_q;
    bubble_c = 1'b0;
    if (flush) begin
      data_d   = '0;
      ctrl_d   = '0;
      valid_d  = 1'b0;
      bubble_c = 1'b1;
    end else if (!freeze) begin
      data_d   = data_in_c;
      ctrl_d   = cond_pass ? ctrl_in : '0;
      valid_d  = cond_pass;
      bubble_c = !cond_pass;
    end
    cnt_d = (bubble_c && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign {pc, val_rn, val_rm, imm, shift_operand, signed_imm24,
          dest, src1, src2, carry} = data_q;
  assign {s, b, exe_cmd, mem_w_en, mem_r_en, wb_en} = ctrl_q;
  assign valid      = valid_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus random traffic
// compared against a field-level reference model of the stage.
module tb_id_ex_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, freeze, flush, cond_pass;
  logic [8:0]        ctrl_in;
  logic [DATA_W-1:0] pc_in, val_rn_in, val_rm_in;
  logic              imm_in, carry_in;
  logic [11:0]       shift_operand_in;
  logic [23:0]       signed_imm24_in;
  logic [3:0]        dest_in, src1_in, src2_in;

  logic              wb_en, mem_r_en, mem_w_en, b, s, imm, carry, valid;
  logic [3:0]        exe_cmd, dest, src1, src2;
  logic [DATA_W-1:0] pc, val_rn, val_rm;
  logic [11:0]       shift_operand;
  logic [23:0]       signed_imm24;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [8:0]        m_ctrl;
  logic [DATA_W-1:0] m_pc, m_rn, m_rm;
  logic              m_imm, m_carry, m_valid;
  logic [11:0]       m_shift;
  logic [23:0]       m_simm;
  logic [3:0]        m_dest, m_src1, m_src2;
  int                m_cnt;

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .ctrl_in(ctrl_in), .cond_pass(cond_pass),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .imm_in(imm_in), .shift_operand_in(shift_operand_in),
    .signed_imm24_in(signed_imm24_in), .dest_in(dest_in),
    .src1_in(src1_in), .src2_in(src2_in), .carry_in(carry_in),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b), .s(s),
    .exe_cmd(exe_cmd), .pc(pc), .val_rn(val_rn), .val_rm(val_rm), .imm(imm),
    .shift_operand(shift_operand), .signed_imm24(signed_imm24), .dest(dest),
    .src1(src1), .src2(src2), .carry(carry), .valid(valid),
    .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stage();
    m_ctrl = '0; m_pc = '0; m_rn = '0; m_rm = '0; m_imm = 1'b0;
    m_shift = '0; m_simm = '0; m_dest = '0; m_src1 = '0; m_src2 = '0;
    m_carry = 1'b0; m_valid = 1'b0;
  endtask

  task automatic add_bubble();
    m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".s"},        64'(s),        64'(m_ctrl[8]));
    chk({tag, ".b"},        64'(b),        64'(m_ctrl[7]));
    chk({tag, ".exe_cmd"},  64'(exe_cmd),  64'(m_ctrl[6:3]));
    chk({tag, ".mem_w_en"}, 64'(mem_w_en), 64'(m_ctrl[2]));
    chk({tag, ".mem_r_en"}, 64'(mem_r_en), 64'(m_ctrl[1]));
    chk({tag, ".wb_en"},    64'(wb_en),    64'(m_ctrl[0]));
    chk({tag, ".pc"},       64'(pc),       64'(m_pc));
    chk({tag, ".val_rn"},   64'(val_rn),   64'(m_rn));
    chk({tag, ".val_rm"},   64'(val_rm),   64'(m_rm));
    chk({tag, ".imm"},      64'(imm),      64'(m_imm));
    chk({tag, ".shift"},    64'(shift_operand), 64'(m_shift));
    chk({tag, ".simm24"},   64'(signed_imm24),  64'(m_simm));
    chk({tag, ".dest"},     64'(dest),     64'(m_dest));
    chk({tag, ".src1"},     64'(src1),     64'(m_src1));
    chk({tag, ".src2"},     64'(src2),     64'(m_src2));
    chk({tag, ".carry"},    64'(carry),    64'(m_carry));
    chk({tag, ".valid"},    64'(valid),    64'(m_valid));
    chk({tag, ".cnt"},      64'(bubble_cnt), 64'(m_cnt));
  endtask

  // One clock edge: advance the model from the applied inputs, then compare.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) begin
      clear_stage();
      m_cnt = 0;
    end else if (flush) begin
      clear_stage();
      add_bubble();
    end else if (!freeze) begin
      m_pc = pc_in; m_rn = val_rn_in; m_rm = val_rm_in; m_imm = imm_in;
      m_shift = shift_operand_in; m_simm = signed_imm24_in; m_dest = dest_in;
      m_src1 = src1_in; m_src2 = src2_in; m_carry = carry_in;
      m_ctrl  = cond_pass ? ctrl_in : 9'd0;
      m_valid = cond_pass;
      if (!cond_pass) add_bubble();
    end
    #1;
    check_all(tag);
  endtask

  task automatic rand_data();
    ctrl_in = 9'($urandom); pc_in = $urandom; val_rn_in = $urandom;
    val_rm_in = $urandom; imm_in = 1'($urandom); carry_in = 1'($urandom);
    shift_operand_in = 12'($urandom); signed_imm24_in = 24'($urandom);
    dest_in = 4'($urandom); src1_in = 4'($urandom); src2_in = 4'($urandom);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; cond_pass = 1'b1;
    rand_data();
    m_cnt = 0;
    clear_stage();
    tick("reset");
    chk("reset.valid_zero", 64'(valid), 64'd0);
    rst = 1'b0;

    // Plain load with condition passed
    ctrl_in = 9'b0_0_0010_0_0_1; cond_pass = 1'b1; pc_in = 32'h10; dest_in = 4'h3;
    tick("load");
    chk("load.wb_en_1", 64'(wb_en), 64'd1);
    chk("load.exe_2",   64'(exe_cmd), 64'd2);
    chk("load.pc_10",   64'(pc), 64'h10);
    chk("load.dest_3",  64'(dest), 64'd3);
    chk("load.valid_1", 64'(valid), 64'd1);

    // Condition fail squashes control but data still loads
    ctrl_in = 9'b1_0_0100_1_0_0; cond_pass = 1'b0; val_rn_in = 32'hAA;
    tick("cfail");
    chk("cfail.s_0",      64'(s), 64'd0);
    chk("cfail.memw_0",   64'(mem_w_en), 64'd0);
    chk("cfail.exe_0",    64'(exe_cmd), 64'd0);
    chk("cfail.valid_0",  64'(valid), 64'd0);
    chk("cfail.rn_aa",    64'(val_rn), 64'hAA);
    chk("cfail.cnt_1",    64'(bubble_cnt), 64'd1);

    // Illegal read+write control combination passes through
    rand_data(); ctrl_in = 9'b0_1_1111_1_1_1; cond_pass = 1'b1;
    tick("illegal");
    chk("illegal.rw", 64'({mem_r_en, mem_w_en}), 64'b11);

    // Freeze holds everything for three cycles despite changing inputs
    rand_data(); cond_pass = 1'b1;
    tick("frz_load");
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data(); cond_pass = 1'(i & 1);
      tick("freeze");
    end
    chk("freeze.cnt_held", 64'(bubble_cnt), 64'd1);

    // Flush wins over freeze
    flush = 1'b1;
    tick("flush_frz");
    chk("flush_frz.valid", 64'(valid), 64'd0);
    chk("flush_frz.cnt_2", 64'(bubble_cnt), 64'd2);
    flush = 1'b0; freeze = 1'b0;

    // Flush together with a failed condition counts once
    cond_pass = 1'b0; flush = 1'b1;
    tick("flush_cf");
    chk("flush_cf.cnt_3", 64'(bubble_cnt), 64'd3);
    flush = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_data();
      rst       = ($urandom_range(0, 49) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      freeze    = ($urandom_range(0, 3) == 0);
      cond_pass = ($urandom_range(0, 3) != 0);
      tick("rand");
    end
    rst = 1'b0; flush = 1'b0; freeze = 1'b0;

    // Saturation after 20 consecutive flushes
    flush = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_data();
      tick("sat");
    end
    chk("sat.cnt_f", 64'(bubble_cnt), 64'hF);
    tick("sat_hold");
    chk("sat.cnt_stays_f", 64'(bubble_cnt), 64'hF);
    flush = 1'b0;

    // Reset priority with bubble_cnt at 5
    rst = 1'b1; tick("rp_rst"); rst = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 5; i++) tick("rp_pre");
    chk("rp.cnt_5", 64'(bubble_cnt), 64'd5);
    rst = 1'b1; freeze = 1'b1;
    tick("rp");
    chk("rp.cnt_0",   64'(bubble_cnt), 64'd0);
    chk("rp.valid_0", 64'(valid), 64'd0);

    // Reset mid-freeze, then normal priority once released
    rst = 1'b0; flush = 1'b0; freeze = 1'b0; cond_pass = 1'b1; rand_data();
    tick("mf_load");
    freeze = 1'b1; rand_data();
    tick("mf_frz");
    rst = 1'b1;
    tick("mf_rst");
    rst = 1'b0; rand_data();
    tick("mf_frz_after");
    chk("mf.valid_held_0", 64'(valid), 64'd0);
    freeze = 1'b0; rand_data(); cond_pass = 1'b1;
    tick("mf_release");
    chk("mf.valid_1", 64'(valid), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
